// File: rtl/coin_acceptor.sv
// coin_acceptor: turns the two raw coin-slot sensors into a clean,
// single-cycle coin code for the vending-machine FSM.
// Each sensor is synchronised (2-FF) and then debounced.
// Double-sensor events are rejected with a coin_err pulse.
// Each coin must be released and followed by a lockout gap before the next
// coin is accepted.
module coin_acceptor #(
    parameter int DEB_CYC = 500000,
    parameter int GAP_CYC = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor_half,
    input  logic       sensor_one,
    output logic [1:0] coin,
    output logic       coin_err
);

    localparam int MAX_CYC = (DEB_CYC > GAP_CYC) ? DEB_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        EMIT     = 3'd2,
        WAIT_REL = 3'd3,
        GAP      = 3'd4
    } state_t;

    // bit 0 = half-yuan sensor, bit 1 = one-yuan sensor
    logic [1:0] raw;
    logic [1:0] sync_vec;
    logic       s_half;
    logic       s_one;

    assign raw    = {sensor_one, sensor_half};
    assign s_half = sync_vec[0];
    assign s_one  = sync_vec[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            // Two-flop synchroniser for one asynchronous sensor
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= raw[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_vec[gi] = sync_reg;
        end
    endgenerate

    // The synchronisers come out of reset holding zeros that do not reflect the
    // real sensors. WAIT_REL must not treat those zeros as a release, otherwise
    // a sensor held through reset would later be counted as a coin. primed_reg
    // marks when the second synchroniser stage carries a genuine sample.
    logic [1:0] primed_reg;

    // Shift in ones after reset until both synchroniser stages hold real data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed_reg <= 2'b00;
        end else begin
            primed_reg <= {primed_reg[0], 1'b1};
        end
    end

    state_t           state_reg,  state_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic             sel_reg,    sel_next;     // 1 = one-yuan slot
    logic [1:0]       coin_reg,   coin_next;
    logic             err_reg,    err_next;

    // Sensor chosen at debounce start, and the sensor that was not chosen
    logic sel_level;
    logic other_level;

    assign sel_level   = sel_reg ? s_one  : s_half;
    assign other_level = sel_reg ? s_half : s_one;

    // State, counter, selected-slot and registered-output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= WAIT_REL;
            cnt_reg   <= CNT_ZERO;
            sel_reg   <= 1'b0;
            coin_reg  <= 2'b00;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sel_reg   <= sel_next;
            coin_reg  <= coin_next;
            err_reg   <= err_next;
        end
    end

    // Next-state, counter and slot-select decisions from synchronised sensors
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sel_next   = sel_reg;
        case (state_reg)
            IDLE: begin
                if (s_half && s_one) begin
                    state_next = WAIT_REL;
                end else if (s_half || s_one) begin
                    state_next = DEBOUNCE;
                    sel_next   = s_one;
                    cnt_next   = CNT_ONE;
                end
            end
            DEBOUNCE: begin
                // A second sensor rising is a double event even if the first
                // one dropped in the same cycle.
                if (other_level) begin
                    state_next = WAIT_REL;
                end else if (!sel_level) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == DEB_LAST) begin
                        state_next = EMIT;
                    end
                end
            end
            EMIT: begin
                state_next = WAIT_REL;
            end
            WAIT_REL: begin
                if (primed_reg[1] && !s_half && !s_one) begin
                    state_next = GAP;
                    cnt_next   = CNT_ZERO;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = WAIT_REL;
                cnt_next   = CNT_ZERO;
            end
        endcase
    end

    // Output decode; both outputs are registered one cycle later.
    // The coin pulse follows EMIT and the error pulse follows IDLE/DEBOUNCE,
    // so the two can never be high in the same cycle.
    always_comb begin
        coin_next = 2'b00;
        err_next  = 1'b0;
        case (state_reg)
            IDLE:     err_next  = s_half && s_one;
            DEBOUNCE: err_next  = other_level;
            EMIT:     coin_next = sel_reg ? 2'b10 : 2'b01;
            default: begin
                coin_next = 2'b00;
                err_next  = 1'b0;
            end
        endcase
    end

    assign coin     = coin_reg;
    assign coin_err = err_reg;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed testbench for coin_acceptor with DEB_CYC=4, GAP_CYC=3.
module tb_coin_acceptor;

    localparam int DEB = 4;
    localparam int GAP = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sensor_half;
    logic       sensor_one;
    logic [1:0] coin;
    logic       coin_err;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Running event counts gathered on the falling edge
    int         n_half = 0;
    int         n_one  = 0;
    int         n_err  = 0;
    int         n_bad  = 0;
    logic [1:0] prev_coin = 2'b00;
    logic       prev_err  = 1'b0;

    always #5 clk = ~clk;

    coin_acceptor #(
        .DEB_CYC(DEB),
        .GAP_CYC(GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sensor_half(sensor_half),
        .sensor_one (sensor_one),
        .coin       (coin),
        .coin_err   (coin_err)
    );

    // Count coin codes and error pulses, and flag any malformed output
    always @(negedge clk) begin
        if (rst_n) begin
            if (coin == 2'b01) n_half = n_half + 1;
            if (coin == 2'b10) n_one  = n_one + 1;
            if (coin == 2'b11) n_bad  = n_bad + 1;
            if (coin_err)      n_err  = n_err + 1;
            if (coin != 2'b00 && coin_err)       n_bad = n_bad + 1;
            if (coin != 2'b00 && prev_coin != 2'b00) n_bad = n_bad + 1;
            if (coin_err && prev_err)            n_bad = n_bad + 1;
            prev_coin = coin;
            prev_err  = coin_err;
        end else begin
            prev_coin = 2'b00;
            prev_err  = 1'b0;
        end
    end

    // Raw sensors high for exactly n sampling edges, then low
    task automatic pulse(input logic h, input logic o, input int n);
        @(posedge clk);
        #1;
        sensor_half = h;
        sensor_one  = o;
        repeat (n) @(posedge clk);
        #1;
        sensor_half = 1'b0;
        sensor_one  = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic test_reset();
        int h0, o0, e0;
        rst_n       = 1'b0;
        sensor_half = 1'b0;
        sensor_one  = 1'b0;
        #3;
        check_cnt++;
        if (coin !== 2'b00) $display("FAIL reset_coin: got %b expected 00", coin);
        else pass_cnt++;
        check_cnt++;
        if (coin_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", coin_err);
        else pass_cnt++;
        settle(3);
        h0 = n_half; o0 = n_one; e0 = n_err;
        @(negedge clk);
        rst_n = 1'b1;
        settle(10);
        check_cnt++;
        if ((n_half - h0) + (n_one - o0) + (n_err - e0) !== 0)
            $display("FAIL reset_quiet: got %0d events expected 0",
                     (n_half - h0) + (n_one - o0) + (n_err - e0));
        else pass_cnt++;
        $display("test_reset: done");
    endtask

    task automatic test_clean_half();
        int first_edge;
        int pulses;
        logic [1:0] first_val;
        int e0;
        first_edge = -1;
        first_val  = 2'b00;
        pulses     = 0;
        e0         = n_err;
        @(posedge clk);
        #1 sensor_half = 1'b1;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            #2;
            if (coin != 2'b00) begin
                pulses++;
                if (first_edge < 0) begin
                    first_edge = e;
                    first_val  = coin;
                end
            end
            if (e == 19) sensor_half = 1'b0;
        end
        check_cnt++;
        if (first_edge !== 6) $display("FAIL clean_latency: got edge %0d expected 6", first_edge);
        else pass_cnt++;
        check_cnt++;
        if (first_val !== 2'b01) $display("FAIL clean_code: got %b expected 01", first_val);
        else pass_cnt++;
        check_cnt++;
        if (pulses !== 1) $display("FAIL clean_width: got %0d cycles expected 1", pulses);
        else pass_cnt++;
        check_cnt++;
        if (n_err - e0 !== 0) $display("FAIL clean_err: got %0d expected 0", n_err - e0);
        else pass_cnt++;
        $display("test_clean_half: first_edge=%0d code=%b cycles=%0d", first_edge, first_val, pulses);
    endtask

    task automatic test_glitch();
        int h0, o0, e0;
        h0 = n_half; o0 = n_one; e0 = n_err;
        pulse(1'b0, 1'b1, DEB - 1);
        settle(12);
        check_cnt++;
        if ((n_half - h0) + (n_one - o0) !== 0)
            $display("FAIL glitch_coin: got %0d coins expected 0", (n_half - h0) + (n_one - o0));
        else pass_cnt++;
        check_cnt++;
        if (n_err - e0 !== 0) $display("FAIL glitch_err: got %0d expected 0", n_err - e0);
        else pass_cnt++;
        pulse(1'b0, 1'b1, 10);
        settle(15);
        check_cnt++;
        if (n_one - o0 !== 1) $display("FAIL one_coin: got %0d expected 1", n_one - o0);
        else pass_cnt++;
        check_cnt++;
        if (n_half - h0 !== 0) $display("FAIL one_coin_half: got %0d expected 0", n_half - h0);
        else pass_cnt++;
        $display("test_glitch: one=%0d half=%0d", n_one - o0, n_half - h0);
    endtask

    task automatic test_double();
        int h0, o0, e0;
        h0 = n_half; o0 = n_one; e0 = n_err;
        pulse(1'b1, 1'b1, 10);
        settle(12);
        check_cnt++;
        if (n_err - e0 !== 1) $display("FAIL double_err: got %0d expected 1", n_err - e0);
        else pass_cnt++;
        check_cnt++;
        if ((n_half - h0) + (n_one - o0) !== 0)
            $display("FAIL double_coin: got %0d expected 0", (n_half - h0) + (n_one - o0));
        else pass_cnt++;
        pulse(1'b1, 1'b0, 6);
        settle(12);
        check_cnt++;
        if (n_half - h0 !== 1) $display("FAIL double_then_half: got %0d expected 1", n_half - h0);
        else pass_cnt++;
        check_cnt++;
        if (n_err - e0 !== 1) $display("FAIL double_err_total: got %0d expected 1", n_err - e0);
        else pass_cnt++;
        $display("test_double: err=%0d half=%0d", n_err - e0, n_half - h0);
    endtask

    task automatic test_lockout();
        int h0, e0;
        h0 = n_half; e0 = n_err;
        pulse(1'b1, 1'b0, 100);
        pulse(1'b1, 1'b0, 2);   // lands inside GAP
        settle(12);
        check_cnt++;
        if (n_half - h0 !== 1) $display("FAIL lockout_single: got %0d expected 1", n_half - h0);
        else pass_cnt++;
        pulse(1'b1, 1'b0, 10);
        settle(15);
        check_cnt++;
        if (n_half - h0 !== 2) $display("FAIL lockout_second: got %0d expected 2", n_half - h0);
        else pass_cnt++;
        check_cnt++;
        if (n_err - e0 !== 0) $display("FAIL lockout_err: got %0d expected 0", n_err - e0);
        else pass_cnt++;
        $display("test_lockout: half=%0d", n_half - h0);
    endtask

    task automatic test_reset_mid();
        int h0, o0, e0;
        @(posedge clk);
        #1 sensor_half = 1'b1;
        repeat (4) @(posedge clk);      // now in DEBOUNCE
        #2 rst_n = 1'b0;
        #1;
        check_cnt++;
        if (coin !== 2'b00) $display("FAIL mid_reset_coin: got %b expected 00", coin);
        else pass_cnt++;
        check_cnt++;
        if (coin_err !== 1'b0) $display("FAIL mid_reset_err: got %b expected 0", coin_err);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        h0 = n_half; o0 = n_one; e0 = n_err;
        @(negedge clk);
        rst_n = 1'b1;
        settle(20);                      // sensor still held high
        check_cnt++;
        if ((n_half - h0) + (n_one - o0) + (n_err - e0) !== 0)
            $display("FAIL held_through_reset: got %0d events expected 0",
                     (n_half - h0) + (n_one - o0) + (n_err - e0));
        else pass_cnt++;
        #1 sensor_half = 1'b0;
        settle(10);
        check_cnt++;
        if (n_half - h0 !== 0) $display("FAIL late_pulse: got %0d expected 0", n_half - h0);
        else pass_cnt++;
        pulse(1'b1, 1'b0, DEB);
        settle(12);
        check_cnt++;
        if (n_half - h0 !== 1) $display("FAIL fresh_after_reset: got %0d expected 1", n_half - h0);
        else pass_cnt++;
        $display("test_reset_mid: half=%0d", n_half - h0);
    endtask

    task automatic test_reset_pulse();
        int h0, o0, e0;
        @(posedge clk);
        #1 sensor_one = 1'b1;
        repeat (7) @(posedge clk);      // edge 6: coin just registered
        #1;
        check_cnt++;
        if (coin !== 2'b10) $display("FAIL one_before_reset: got %b expected 10", coin);
        else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        check_cnt++;
        if (coin !== 2'b00) $display("FAIL async_clear: got %b expected 00", coin);
        else pass_cnt++;
        sensor_one = 1'b0;
        h0 = n_half; o0 = n_one; e0 = n_err;
        @(negedge clk);
        rst_n = 1'b1;
        settle(15);
        check_cnt++;
        if ((n_half - h0) + (n_one - o0) + (n_err - e0) !== 0)
            $display("FAIL after_pulse_reset: got %0d events expected 0",
                     (n_half - h0) + (n_one - o0) + (n_err - e0));
        else pass_cnt++;
        $display("test_reset_pulse: done");
    endtask

    task automatic test_random();
        int b0, c0, coins;
        logic h, o, in_range;
        int len;
        b0 = n_bad;
        c0 = n_half + n_one;
        for (int i = 0; i < 40; i++) begin
            h   = 1'($urandom_range(0, 1));
            o   = 1'($urandom_range(0, 1));
            if (!h && !o) h = 1'b1;
            len = $urandom_range(1, 12);
            pulse(h, o, len);
            settle($urandom_range(0, 8));
        end
        settle(15);
        coins    = n_half + n_one - c0;
        in_range = (coins <= 40);
        check_cnt++;
        if (n_bad - b0 !== 0) $display("FAIL random_shape: got %0d bad cycles expected 0", n_bad - b0);
        else pass_cnt++;
        check_cnt++;
        if (in_range !== 1'b1) $display("FAIL random_count: got %0d coins expected at most 40", coins);
        else pass_cnt++;
        $display("test_random: coins=%0d", coins);
    endtask

    initial begin
        test_reset();
        test_clean_half();
        test_glitch();
        test_double();
        test_lockout();
        test_reset_mid();
        test_reset_pulse();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
